// File: rtl/fetch_unit_if.sv
`timescale 1ns/1ps
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and IF/ID register outputs.
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_unit_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_next;
    logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_rvalid, imem_rdata,
`ifdef FETCH_PERF_CNT_EN
        output perf_fetch_cnt, perf_stall_cnt,
`endif
        output imem_req, imem_addr, if_valid, if_pc, if_instr, if_pc_next, fetch_busy
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_rvalid, imem_rdata,
`ifdef FETCH_PERF_CNT_EN
        input  perf_fetch_cnt, perf_stall_cnt,
`endif
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, if_pc_next, fetch_busy
    );
endinterface

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests, writes IF/ID.
// Define FETCH_PERF_CNT_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DISCARD} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        if_valid_reg;
    logic [31:0] if_pc_reg;
    logic [31:0] if_instr_reg;
    logic [31:0] if_pc_next_reg;
    logic        busy_reg;
    logic        consume;
    logic [31:0] redirect_target;
    logic [1:0]  unused_redirect_low;

    assign redirect_target     = {bus.redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_low = bus.redirect_pc_i[1:0];
    assign consume             = (state_reg == HOLD) && !bus.stall_i;

    // The next request goes out in the same cycle the held instruction is consumed.
    assign bus.imem_req   = !bus.redirect_i && ((state_reg == REQ) || consume);
    assign bus.imem_addr  = pc_reg;
    assign bus.if_valid   = if_valid_reg;
    assign bus.if_pc      = if_pc_reg;
    assign bus.if_instr   = if_instr_reg;
    assign bus.if_pc_next = if_pc_next_reg;
    assign bus.fetch_busy = busy_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            if_valid_reg   <= 1'b0;
            if_pc_reg      <= 32'h0;
            if_instr_reg   <= NOP_INSTR;
            if_pc_next_reg <= 32'h0;
            busy_reg       <= 1'b0;
        end else if (bus.redirect_i) begin
            pc_reg       <= redirect_target;
            if_valid_reg <= 1'b0;
            if_instr_reg <= NOP_INSTR;
            // A response still in flight must be swallowed; one arriving now is simply dropped.
            if ((state_reg == WAIT || state_reg == DISCARD) && !bus.imem_rvalid) begin
                state_reg <= DISCARD;
                busy_reg  <= 1'b1;
            end else begin
                state_reg <= REQ;
                busy_reg  <= 1'b0;
            end
        end else begin
            case (state_reg)
                IDLE: state_reg <= REQ;
                REQ: begin
                    state_reg <= WAIT;
                    busy_reg  <= 1'b1;
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        if_instr_reg   <= bus.imem_rdata;
                        if_pc_reg      <= pc_reg;
                        if_pc_next_reg <= pc_reg + 32'd4;
                        if_valid_reg   <= 1'b1;
                        pc_reg         <= pc_reg + 32'd4;
                        state_reg      <= HOLD;
                        busy_reg       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!bus.stall_i) begin
                        if_valid_reg <= 1'b0;
                        if_instr_reg <= NOP_INSTR;
                        state_reg    <= WAIT;
                        busy_reg     <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (bus.imem_rvalid) begin
                        state_reg <= REQ;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_reg <= 32'h0;
            perf_stall_reg <= 32'h0;
        end else begin
            if (consume && !bus.redirect_i) begin
                perf_fetch_reg <= perf_fetch_reg + 32'd1;
            end
            if ((state_reg == HOLD) && bus.stall_i) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign bus.perf_fetch_cnt = perf_fetch_reg;
    assign bus.perf_stall_cnt = perf_stall_reg;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Bench for fetch_unit: directed scenarios then randomized traffic against a transaction-level model.
// A second instance with RESET_PC=FFFFFFFC runs alongside to check PC wrap-around.
module tb_fetch_unit;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();
    fetch_unit_if bus2();

    fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut  (.clk(clk), .rst(rst), .bus(bus));
    fetch_unit #(.RESET_PC(RPC2),  .NOP_INSTR(NOP)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: expected fetch address, presented instruction, outstanding request.
    logic        m_valid;
    logic [31:0] m_pc, m_if_pc, m_if_instr;
    logic        outst, killed;
    logic [31:0] o_addr, o_data;
    int          o_cnt;
    int          n_accept;
    logic [31:0] m_fetch_cnt, m_stall_cnt;

    // Memory/stimulus knobs
    int   dly_min, dly_max, spur_pct;
    logic fixed_data, spur_force;

    // Samples taken at the falling edge
    logic        s_req, s_valid, s_busy;
    logic [31:0] s_addr, s_pc, s_instr, s_pcn, s_pf, s_ps;
    logic        s2_req, s2_valid, d2_pend;
    logic [31:0] s2_addr, s2_pc, s2_pcn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pc = 32'h0; m_if_pc = 32'h0; m_if_instr = NOP;
        outst = 1'b0; killed = 1'b0; o_addr = 32'h0; o_data = 32'h0; o_cnt = 0;
        m_fetch_cnt = 32'h0; m_stall_cnt = 32'h0; d2_pend = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc, input logic rv);
        logic was_valid;
        check("busy", s_busy, outst);
        check("valid", s_valid, m_valid);
        if (m_valid) begin
            check("if_pc", s_pc, m_if_pc);
            check("if_instr", s_instr, m_if_instr);
            check("if_pc_next", s_pcn, m_if_pc + 32'd4);
        end else begin
            check("nop_instr", s_instr, NOP);
        end
        if (rd) check("req_in_redirect", s_req, 1'b0);
        else if (m_valid) check("req_in_hold", s_req, !st);
        if (outst) check("req_while_outstanding", s_req, 1'b0);
        if (s_req) check("imem_addr", s_addr, m_pc);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch", s_pf, m_fetch_cnt);
        check("perf_stall", s_ps, m_stall_cnt);
`endif
        was_valid = m_valid;
        if (was_valid && st) m_stall_cnt++;
        if (was_valid && !st && !rd) begin
            m_valid = 1'b0;
            m_fetch_cnt++;
        end
        if (rv && outst) begin
            outst = 1'b0;
            if (!killed && !rd) begin
                m_valid    = 1'b1;
                m_if_pc    = o_addr;
                m_if_instr = o_data;
                m_pc       = o_addr + 32'd4;
                n_accept++;
            end
        end
        if (rd) begin
            m_valid = 1'b0;
            m_pc    = {rpc[31:2], 2'b00};
            if (outst) killed = 1'b1;
        end
        if (s_req && !rd) begin
            outst  = 1'b1;
            killed = 1'b0;
            o_addr = s_addr;
            o_data = fixed_data ? ADDI : $urandom;
            o_cnt  = int'($urandom_range(dly_max, dly_min));
        end
    endtask

    // One clock cycle: drive at posedge+1, sample/check at negedge, return at next posedge+1.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
        logic        rv;
        logic [31:0] rdat;
        rv   = 1'b0;
        rdat = $urandom;
        if (outst && o_cnt == 0) begin
            rv   = 1'b1;
            rdat = o_data;
        end else begin
            if (outst) o_cnt--;
            if (!outst && (spur_force || ($urandom_range(99, 0) < spur_pct))) rv = 1'b1;
        end
        bus.stall_i       = st;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.imem_rvalid   = rv;
        bus.imem_rdata    = rdat;
        bus2.stall_i       = 1'b0;
        bus2.redirect_i    = 1'b0;
        bus2.redirect_pc_i = 32'h0;
        bus2.imem_rvalid   = d2_pend;
        bus2.imem_rdata    = ADDI;
        @(negedge clk);
        s_req = bus.imem_req;  s_addr = bus.imem_addr; s_valid = bus.if_valid;
        s_pc = bus.if_pc;      s_instr = bus.if_instr; s_pcn = bus.if_pc_next;
        s_busy = bus.fetch_busy;
`ifdef FETCH_PERF_CNT_EN
        s_pf = bus.perf_fetch_cnt;
        s_ps = bus.perf_stall_cnt;
`else
        s_pf = 32'h0;
        s_ps = 32'h0;
`endif
        s2_req = bus2.imem_req; s2_addr = bus2.imem_addr; s2_valid = bus2.if_valid;
        s2_pc = bus2.if_pc;     s2_pcn = bus2.if_pc_next;
        d2_pend = s2_req;
        model_step(st, rd, rpc, rv);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        model_reset();
        repeat (n) tick(1'b0, 1'b0, 32'h0);
        check("rst_valid", s_valid, 1'b0);
        check("rst_instr", s_instr, NOP);
        check("rst_pc", s_pc, 32'h0);
        check("rst_pc_next", s_pcn, 32'h0);
        check("rst_req", s_req, 1'b0);
        check("rst_busy", s_busy, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_fetch", s_pf, 32'h0);
        check("rst_perf_stall", s_ps, 32'h0);
`endif
        rst = 1'b1;
    endtask

    initial begin
        bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus2.stall_i = 1'b0; bus2.redirect_i = 1'b0; bus2.redirect_pc_i = 32'h0;
        bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0;
        dly_min = 0; dly_max = 0; spur_pct = 0; fixed_data = 1'b1; spur_force = 1'b0;
        n_accept = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Back-to-back fetch, immediate memory
        do_reset(3);
        tick(1'b0, 1'b0, 32'h0);
        check("idle_no_req", s_req, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        check("first_req", s_req, 1'b1);
        check("first_addr", s_addr, 32'h0);
        check("wrap_first_addr", s2_addr, RPC2);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("hold0_valid", s_valid, 1'b1);
        check("hold0_pc", s_pc, 32'h0);
        check("hold0_pc_next", s_pcn, 32'h4);
        check("hold0_instr", s_instr, ADDI);
        check("second_req_2cyc", s_req, 1'b1);
        check("second_addr", s_addr, 32'h4);
        check("wrap_if_pc", s2_pc, RPC2);
        check("wrap_if_pc_next", s2_pcn, 32'h0);
        check("wrap_second_addr", s2_addr, 32'h0);
        tick(1'b0, 1'b0, 32'h0);

        // Stall for three cycles holding the instruction at 0x4
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            check("stall_valid", s_valid, 1'b1);
            check("stall_pc", s_pc, 32'h4);
            check("stall_instr", s_instr, ADDI);
            check("stall_no_req", s_req, 1'b0);
        end
        dly_min = 2; dly_max = 2;
        tick(1'b0, 1'b0, 32'h0);
        check("post_stall_addr", s_addr, 32'h8);
        dly_min = 0; dly_max = 0;

        // Redirect while waiting; late response must be discarded
        tick(1'b0, 1'b1, 32'h100);
        check("redir_wait_no_req", s_req, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        check("discard_busy", s_busy, 1'b1);
        tick(1'b0, 1'b0, 32'h0);
        check("discard_valid", s_valid, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        check("redir_req", s_req, 1'b1);
        check("redir_addr", s_addr, 32'h100);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("redir_if_pc", s_pc, 32'h100);

        // Redirect in the same cycle as the response; unaligned target
        tick(1'b0, 1'b1, 32'h203);
        tick(1'b0, 1'b0, 32'h0);
        check("unaligned_addr", s_addr, 32'h200);
        tick(1'b0, 1'b0, 32'h0);
        dly_min = 3; dly_max = 3;
        tick(1'b0, 1'b0, 32'h0);
        check("after_drop_pc", s_pc, 32'h200);
        check("after_drop_pc_next", s_pcn, 32'h204);
        dly_min = 0; dly_max = 0;
        tick(1'b0, 1'b0, 32'h0);
        check("midwait_busy", s_busy, 1'b1);

        // Reset in the middle of WAIT, then a stray response during IDLE
        do_reset(2);
        spur_force = 1'b1;
        tick(1'b0, 1'b0, 32'h0);
        spur_force = 1'b0;
        check("stray_valid", s_valid, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        check("post_rst_addr", s_addr, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("post_rst_pc", s_pc, 32'h0);

        // Randomized traffic
        do_reset(2);
        fixed_data = 1'b0; dly_min = 0; dly_max = 3; spur_pct = 10;
        n_accept = 0;
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 8, $urandom);
        end
        check("progress", n_accept >= 150, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
